// File: rtl/ram_sp_be_clr_if.sv
// Bus-side signal bundle for ram_sp_be_clr: access strobes in, read data and status out.
interface ram_sp_be_clr_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
);
  logic                  cs;
  logic                  rd;
  logic                  wr;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     data_in;
  logic [DATA_W/8-1:0]   be;
  logic                  clear;
  logic [DATA_W-1:0]     d_out;
  logic                  d_valid;
  logic                  busy;
  logic                  err;

  modport master (
    output cs, rd, wr, addr, data_in, be, clear,
    input  d_out, d_valid, busy, err
  );

  modport slave (
    input  cs, rd, wr, addr, data_in, be, clear,
    output d_out, d_valid, busy, err
  );
endinterface

// File: rtl/ram_sp_be_clr.sv
// Single-port synchronous RAM with byte-lane writes, 1- or 2-cycle registered reads,
// a zero-fill engine that runs after reset and on request, and a rejected-access flag.
module ram_sp_be_clr #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 1
) (
  input logic            clk,
  input logic            rst,
  ram_sp_be_clr_if.slave bus
);

  localparam int unsigned NumLanes = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic {StClear, StIdle} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              busy;
  logic              clr_we;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              addr_oob;
  logic              req;
  logic              rd_ok;
  logic              wr_ok;
  logic              bad;

  logic [DATA_W-1:0] d_out_q;
  logic              d_valid_q;
  logic              err_q;

  // Zero-fill FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StClear: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LastAddr) begin
          state_d   = StIdle;
          clr_cnt_d = '0;
        end
      end
      StIdle: begin
        if (bus.clear) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    clr_we = 1'b0;
    unique case (state_q)
      StClear: begin
        busy   = 1'b1;
        clr_we = 1'b1;
      end
      StIdle: begin
        busy   = 1'b0;
        clr_we = 1'b0;
      end
      default: begin
        busy   = 1'b1;
        clr_we = 1'b0;
      end
    endcase
  end

  // Access decode; anything not cleanly a read or a write while idle is rejected
  always_comb begin
    addr_oob = (32'(bus.addr) >= 32'(DEPTH));
    req      = bus.cs & (bus.rd | bus.wr);
    rd_ok    = bus.cs & bus.rd & ~bus.wr & ~busy & ~addr_oob;
    wr_ok    = bus.cs & bus.wr & ~bus.rd & ~busy & ~addr_oob;
    bad      = req & (busy | (bus.rd & bus.wr) | addr_oob);
  end

  // Array has no reset: contents are defined only once the zero-fill has swept it
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NumLanes; i++) begin
        if (bus.be[i]) mem[bus.addr][8*i +: 8] <= bus.data_in[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= bad;
  end

  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        d_out_q   <= '0;
        d_valid_q <= 1'b0;
      end else begin
        d_valid_q <= rd_ok;
        if (rd_ok) d_out_q <= mem[bus.addr];
      end
    end
  end else begin : g_lat2
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_vld_q;

    // Stage 1 captures the array before any zero-fill write can land on it
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q <= '0;
        rd_vld_q  <= 1'b0;
        d_out_q   <= '0;
        d_valid_q <= 1'b0;
      end else begin
        rd_vld_q  <= rd_ok;
        if (rd_ok) rd_data_q <= mem[bus.addr];
        d_valid_q <= rd_vld_q;
        if (rd_vld_q) d_out_q <= rd_data_q;
      end
    end
  end

  assign bus.d_out   = d_out_q;
  assign bus.d_valid = d_valid_q;
  assign bus.busy    = busy;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_ram_sp_be_clr.sv
// Directed bench: dut_a is 8-bit/1024 words/RD_LAT=1, dut_b is 32-bit/1000 words/RD_LAT=2.
module tb_ram_sp_be_clr;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  ram_sp_be_clr_if #(.DATA_W(8),  .ADDR_W(10)) ia ();
  ram_sp_be_clr_if #(.DATA_W(32), .ADDR_W(10)) ib ();

  ram_sp_be_clr #(.DATA_W(8), .ADDR_W(10), .DEPTH(1024), .RD_LAT(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  ram_sp_be_clr #(.DATA_W(32), .ADDR_W(10), .DEPTH(1000), .RD_LAT(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  task automatic a_op(input logic c, input logic r, input logic w, input logic [9:0] ad,
                      input logic [7:0] din, input logic clr);
    ia.cs = c; ia.rd = r; ia.wr = w; ia.addr = ad; ia.data_in = din; ia.be = 1'b1;
    ia.clear = clr;
    @(posedge clk); #1;
    ia.cs = 1'b0; ia.rd = 1'b0; ia.wr = 1'b0; ia.clear = 1'b0;
  endtask

  task automatic b_op(input logic r, input logic w, input logic [9:0] ad,
                      input logic [31:0] din, input logic [3:0] bmask);
    ib.cs = 1'b1; ib.rd = r; ib.wr = w; ib.addr = ad; ib.data_in = din; ib.be = bmask;
    ib.clear = 1'b0;
    @(posedge clk); #1;
    ib.cs = 1'b0; ib.rd = 1'b0; ib.wr = 1'b0;
  endtask

  task automatic test_reset;
    int ca;
    int cb;
    ca = 0;
    cb = 0;
    #3;
    checks++;
    if (ia.busy !== 1'b1 || ia.d_out !== 8'h00 || ia.d_valid !== 1'b0 || ia.err !== 1'b0) begin
      fails++;
      $display("FAIL reset_a: busy/d_out/valid/err got %b/%h/%b/%b expected 1/00/0/0",
               ia.busy, ia.d_out, ia.d_valid, ia.err);
    end
    checks++;
    if (ib.busy !== 1'b1 || ib.d_out !== 32'h0 || ib.d_valid !== 1'b0 || ib.err !== 1'b0) begin
      fails++;
      $display("FAIL reset_b: busy/d_out/valid/err got %b/%h/%b/%b expected 1/0/0/0",
               ib.busy, ib.d_out, ib.d_valid, ib.err);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 3000 && (ia.busy === 1'b1 || ib.busy === 1'b1); n++) begin
      if (ia.busy === 1'b1) ca++;
      if (ib.busy === 1'b1) cb++;
      @(negedge clk);
    end
    checks++;
    if (ca != 1024) begin
      fails++;
      $display("FAIL busy_len_a: got %0d cycles expected 1024", ca);
    end
    checks++;
    if (cb != 1000) begin
      fails++;
      $display("FAIL busy_len_b: got %0d cycles expected 1000", cb);
    end
  endtask

  task automatic test_zero_after_reset;
    logic [9:0] addrs [3];
    addrs[0] = 10'd0; addrs[1] = 10'd511; addrs[2] = 10'd1023;
    for (int i = 0; i < 3; i++) begin
      a_op(1'b1, 1'b1, 1'b0, addrs[i], 8'h00, 1'b0);
      checks++;
      if (ia.d_valid !== 1'b1 || ia.d_out !== 8'h00) begin
        fails++;
        $display("FAIL zero_read[%0d]: valid/d_out got %b/%h expected 1/00", addrs[i],
                 ia.d_valid, ia.d_out);
      end
      @(posedge clk); #1;
      checks++;
      if (ia.d_valid !== 1'b0) begin
        fails++;
        $display("FAIL zero_pulse[%0d]: valid got %b expected 0", addrs[i], ia.d_valid);
      end
    end
  endtask

  task automatic test_write_read;
    a_op(1'b1, 1'b0, 1'b1, 10'd3, 8'hA5, 1'b0);
    a_op(1'b1, 1'b1, 1'b0, 10'd3, 8'h00, 1'b0);
    checks++;
    if (ia.d_valid !== 1'b1 || ia.d_out !== 8'hA5) begin
      fails++;
      $display("FAIL wr_rd_lat1: valid/d_out got %b/%h expected 1/a5", ia.d_valid, ia.d_out);
    end
    b_op(1'b0, 1'b1, 10'd3, 32'h0000_00A5, 4'hF);
    b_op(1'b1, 1'b0, 10'd3, 32'h0, 4'h0);
    checks++;
    if (ib.d_valid !== 1'b0) begin
      fails++;
      $display("FAIL lat2_early: valid got %b expected 0", ib.d_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (ib.d_valid !== 1'b1 || ib.d_out !== 32'h0000_00A5) begin
      fails++;
      $display("FAIL wr_rd_lat2: valid/d_out got %b/%h expected 1/000000a5",
               ib.d_valid, ib.d_out);
    end
    @(posedge clk); #1;
    checks++;
    if (ib.d_valid !== 1'b0) begin
      fails++;
      $display("FAIL lat2_pulse: valid got %b expected 0", ib.d_valid);
    end
  endtask

  task automatic test_byte_enable;
    b_op(1'b0, 1'b1, 10'd5, 32'h1122_3344, 4'hF);
    b_op(1'b0, 1'b1, 10'd5, 32'hAABB_CCDD, 4'b0101);
    b_op(1'b1, 1'b0, 10'd5, 32'h0, 4'h0);
    @(posedge clk); #1;
    checks++;
    if (ib.d_valid !== 1'b1 || ib.d_out !== 32'h11BB_33DD) begin
      fails++;
      $display("FAIL byte_enable: valid/d_out got %b/%h expected 1/11bb33dd",
               ib.d_valid, ib.d_out);
    end
  endtask

  task automatic test_back_to_back;
    b_op(1'b1, 1'b0, 10'd3, 32'h0, 4'h0);
    b_op(1'b1, 1'b0, 10'd5, 32'h0, 4'h0);
    checks++;
    if (ib.d_valid !== 1'b1 || ib.d_out !== 32'h0000_00A5) begin
      fails++;
      $display("FAIL b2b_first: valid/d_out got %b/%h expected 1/000000a5",
               ib.d_valid, ib.d_out);
    end
    @(posedge clk); #1;
    checks++;
    if (ib.d_valid !== 1'b1 || ib.d_out !== 32'h11BB_33DD) begin
      fails++;
      $display("FAIL b2b_second: valid/d_out got %b/%h expected 1/11bb33dd",
               ib.d_valid, ib.d_out);
    end
  endtask

  task automatic test_illegal_rdwr;
    a_op(1'b1, 1'b0, 1'b1, 10'd7, 8'h5A, 1'b0);
    a_op(1'b1, 1'b1, 1'b0, 10'd3, 8'h00, 1'b0);
    a_op(1'b1, 1'b1, 1'b1, 10'd7, 8'h00, 1'b0);
    checks++;
    if (ia.err !== 1'b1 || ia.d_valid !== 1'b0 || ia.d_out !== 8'hA5) begin
      fails++;
      $display("FAIL rdwr_err: err/valid/d_out got %b/%b/%h expected 1/0/a5",
               ia.err, ia.d_valid, ia.d_out);
    end
    @(posedge clk); #1;
    checks++;
    if (ia.err !== 1'b0) begin
      fails++;
      $display("FAIL rdwr_err_pulse: err got %b expected 0", ia.err);
    end
    a_op(1'b0, 1'b0, 1'b1, 10'd7, 8'h00, 1'b0);
    checks++;
    if (ia.err !== 1'b0) begin
      fails++;
      $display("FAIL cs0_no_err: err got %b expected 0", ia.err);
    end
    a_op(1'b1, 1'b1, 1'b0, 10'd7, 8'h00, 1'b0);
    checks++;
    if (ia.d_valid !== 1'b1 || ia.d_out !== 8'h5A) begin
      fails++;
      $display("FAIL rdwr_mem_kept: valid/d_out got %b/%h expected 1/5a", ia.d_valid, ia.d_out);
    end
  endtask

  task automatic test_out_of_range;
    b_op(1'b0, 1'b1, 10'd1000, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if (ib.err !== 1'b1) begin
      fails++;
      $display("FAIL oob_wr_err: err got %b expected 1", ib.err);
    end
    b_op(1'b1, 1'b0, 10'd1000, 32'h0, 4'h0);
    checks++;
    if (ib.err !== 1'b1) begin
      fails++;
      $display("FAIL oob_rd_err: err got %b expected 1", ib.err);
    end
    @(posedge clk); #1;
    checks++;
    if (ib.d_valid !== 1'b0 || ib.d_out !== 32'h11BB_33DD || ib.err !== 1'b0) begin
      fails++;
      $display("FAIL oob_rd_quiet: valid/d_out/err got %b/%h/%b expected 0/11bb33dd/0",
               ib.d_valid, ib.d_out, ib.err);
    end
    b_op(1'b1, 1'b0, 10'd999, 32'h0, 4'h0);
    b_op(1'b1, 1'b0, 10'd488, 32'h0, 4'h0);
    checks++;
    if (ib.d_valid !== 1'b1 || ib.d_out !== 32'h0) begin
      fails++;
      $display("FAIL oob_999_kept: valid/d_out got %b/%h expected 1/0", ib.d_valid, ib.d_out);
    end
    @(posedge clk); #1;
    checks++;
    if (ib.d_valid !== 1'b1 || ib.d_out !== 32'h0) begin
      fails++;
      $display("FAIL oob_488_kept: valid/d_out got %b/%h expected 1/0", ib.d_valid, ib.d_out);
    end
  endtask

  task automatic test_clear;
    int cnt;
    for (int i = 0; i < 4; i++) a_op(1'b1, 1'b0, 1'b1, 10'(i), 8'hFF, 1'b0);
    a_op(1'b1, 1'b1, 1'b0, 10'd2, 8'h00, 1'b1);
    checks++;
    if (ia.d_valid !== 1'b1 || ia.d_out !== 8'hFF || ia.busy !== 1'b1) begin
      fails++;
      $display("FAIL clear_read: valid/d_out/busy got %b/%h/%b expected 1/ff/1",
               ia.d_valid, ia.d_out, ia.busy);
    end
    a_op(1'b1, 1'b0, 1'b1, 10'd9, 8'h77, 1'b0);
    checks++;
    if (ia.err !== 1'b1) begin
      fails++;
      $display("FAIL busy_wr_err: err got %b expected 1", ia.err);
    end
    cnt = 2;
    for (int n = 0; n < 3000 && ia.busy === 1'b1; n++) begin
      @(posedge clk); #1;
      if (ia.busy === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 1024) begin
      fails++;
      $display("FAIL clear_busy_len: got %0d cycles expected 1024", cnt);
    end
    for (int i = 0; i < 4; i++) begin
      a_op(1'b1, 1'b1, 1'b0, 10'(i), 8'h00, 1'b0);
      checks++;
      if (ia.d_valid !== 1'b1 || ia.d_out !== 8'h00) begin
        fails++;
        $display("FAIL cleared[%0d]: valid/d_out got %b/%h expected 1/00", i,
                 ia.d_valid, ia.d_out);
      end
    end
    a_op(1'b1, 1'b1, 1'b0, 10'd9, 8'h00, 1'b0);
    checks++;
    if (ia.d_valid !== 1'b1 || ia.d_out !== 8'h00) begin
      fails++;
      $display("FAIL busy_wr_dropped: valid/d_out got %b/%h expected 1/00",
               ia.d_valid, ia.d_out);
    end
  endtask

  task automatic test_reset_mid_read;
    b_op(1'b1, 1'b0, 10'd5, 32'h0, 4'h0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ib.d_valid !== 1'b0 || ib.d_out !== 32'h0 || ib.busy !== 1'b1) begin
        fails++;
        $display("FAIL rst_mid_read[%0d]: valid/d_out/busy got %b/%h/%b expected 0/0/1", i,
                 ib.d_valid, ib.d_out, ib.busy);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    ia.cs = 1'b0; ia.rd = 1'b0; ia.wr = 1'b0; ia.addr = '0; ia.data_in = '0; ia.be = '0;
    ia.clear = 1'b0;
    ib.cs = 1'b0; ib.rd = 1'b0; ib.wr = 1'b0; ib.addr = '0; ib.data_in = '0; ib.be = '0;
    ib.clear = 1'b0;
    #1 rst = 1'b1;
    test_reset();
    test_zero_after_reset();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_illegal_rdwr();
    test_out_of_range();
    test_clear();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
